pixel_framebuffer: RTL and testbench
====================================

PIXEL_FRAMEBUFFER -- requirements
Module: pixel_framebuffer

Interface
REQ-001 Parameter DEPTH, default 19200, number of 3-bit pixel entries stored.
REQ-002 Parameter CLEAR_RGB, default 3'b000, colour written during a clear sweep.
REQ-003 clock  input  1  single system clock, 25 MHz pixel clock; all logic on its rising edge.
REQ-004 reset  input  1  synchronous, active-high reset.
REQ-005 pixel_address  input  16  read address from the VGA controller.
REQ-006 pixel_rgb  output  3  registered pixel data returned to the VGA controller.
REQ-007 wr_valid  input  1  loader presents a pixel.
REQ-008 wr_ready  output  1  block accepts a pixel this cycle.
REQ-009 wr_rgb  input  3  pixel data from the loader.
REQ-010 wr_first  input  1  qualifies the beat as frame start; it is written to address 0.
REQ-011 clear_req  input  1  one-cycle request to fill the whole buffer with CLEAR_RGB.
REQ-012 busy  output  1  high while the clear sweep runs.
REQ-013 frame_done  output  1  one-cycle pulse after the beat written to address DEPTH-1.

Function
REQ-014 Accepted beat: wr_valid and wr_ready both high on a rising edge; only accepted beats write memory.
REQ-015 FSM has two states: CLEAR (sweep) and LOAD (accept loader beats).
REQ-016 CLEAR: wr_ready=0, busy=1; CLEAR_RGB is written to clr_ptr once per cycle, clr_ptr steps 0..DEPTH-1; after writing DEPTH-1 the FSM moves to LOAD and wr_ptr clears to 0.
REQ-017 The sweep takes exactly DEPTH cycles.
REQ-018 LOAD: wr_ready=1, busy=0; an accepted beat writes wr_rgb to wr_ptr and increments wr_ptr.
REQ-019 Accepted beat with wr_first=1 writes address 0 and sets wr_ptr to 1, whatever wr_ptr held.
REQ-020 Wrap: an accepted beat at wr_ptr=DEPTH-1 sets wr_ptr to 0 and asserts frame_done on the next cycle for one cycle.
REQ-021 clear_req in LOAD: moves the FSM to CLEAR next cycle; a beat accepted in the same cycle is still written.
REQ-022 clear_req during CLEAR restarts the sweep at address 0.
REQ-023 Read latency is exactly 1 cycle: pixel_rgb at edge N+1 = memory[pixel_address sampled at edge N].
REQ-024 pixel_address >= DEPTH: pixel_rgb = 3'b000 on the following cycle.
REQ-025 Read and write to the same address in one cycle return the old data (read-before-write).
REQ-026 Reads are never stalled; they keep working during CLEAR and return partially cleared contents.
REQ-027 wr_ptr and clr_ptr are 16 bits wide; comparisons use DEPTH-1; arithmetic never exceeds DEPTH.

Reset
REQ-028 Reset puts the FSM in CLEAR with clr_ptr=0, wr_ptr=0 and pixel_rgb=3'b000; frame_done=0, wr_ready=0, busy=1.
REQ-029 Reset mid-sweep or mid-frame restarts the sweep from address 0; partial contents are not preserved.
REQ-030 Reset has priority over clear_req and over wr_valid.

Structure
REQ-031 A shared package holds DEPTH default, RGB_W=3, ADDR_W=16, CLEAR_RGB default and the FSM state encoding.
REQ-032 Storage is a separate sub-module, fb_ram: simple dual-port RAM with one synchronous write port and one registered read port, inferable as block RAM.
REQ-033 The FSM, pointers, write mux (clear vs loader) and out-of-range masking stay in pixel_framebuffer.

Verification
REQ-034 Sweep after reset: DEPTH=16, CLEAR_RGB=3'b010, release reset -> busy=1 for 16 cycles, then wr_ready=1; reads of addresses 0..15 return 3'b010.
REQ-035 Frame load and wrap: DEPTH=16, 16 back-to-back beats with rgb=addr[2:0], first beat wr_first=1 -> frame_done pulses once, one cycle after the 16th beat; address 5 reads 3'b101 one cycle after it is presented.
REQ-036 Stall and realign: 3 beats, wr_valid low for 4 cycles, then a wr_first beat with rgb=3'b111 -> address 0 holds 3'b111, wr_ptr=1, addresses 1..2 unchanged.
REQ-037 Simultaneous clear_req and beat at wr_ptr=7 with rgb=3'b001 -> the beat is written, busy rises next cycle, and after the sweep address 7 reads CLEAR_RGB.
REQ-038 Out of range and collision: pixel_address=16'hFFFF -> pixel_rgb=3'b000; same-cycle read/write of address 3 (old 3'b100, new 3'b011) -> 3'b100 first, 3'b011 on the next read.
REQ-039 Reset mid-sweep at clr_ptr=9 -> sweep restarts at 0 and takes the full DEPTH cycles; reset mid-frame -> wr_ptr=0 after the sweep.

Source files
------------

// File: rtl/pixel_framebuffer_pkg.sv
// Shared constants, widths and FSM encoding for the pixel framebuffer.
package pixel_framebuffer_pkg;

  localparam int unsigned DEPTH_DEF = 19200;
  localparam int unsigned RGB_W     = 3;
  localparam int unsigned ADDR_W    = 16;

  localparam logic [RGB_W-1:0] CLEAR_RGB_DEF = 3'b000;

  typedef enum logic [0:0] {
    StClear = 1'b0,
    StLoad  = 1'b1
  } fb_state_e;

  function automatic int unsigned idx_width(input int unsigned depth);
    return (depth > 1) ? $clog2(depth) : 1;
  endfunction

endpackage

// File: rtl/fb_ram.sv
// Simple dual-port RAM: one synchronous write port, one registered read port.
module fb_ram #(
  parameter int unsigned DEPTH = 16,
  parameter int unsigned AW    = 4,
  parameter int unsigned DW    = 3
) (
  input  logic          i_clk,
  input  logic          i_we,
  input  logic [AW-1:0] i_waddr,
  input  logic [DW-1:0] i_wdata,
  input  logic [AW-1:0] i_raddr,
  output logic [DW-1:0] o_rdata
);

  logic [DW-1:0] r_mem [DEPTH];
  logic [DW-1:0] r_rdata;

  // Non-blocking read and write in one process: a colliding read sees the old word.
  always_ff @(posedge i_clk) begin
    if (i_we) begin
      r_mem[i_waddr] <= i_wdata;
    end
    r_rdata <= r_mem[i_raddr];
  end

  assign o_rdata = r_rdata;

endmodule

// File: rtl/pixel_framebuffer.sv
// Frame store between a pixel loader and a VGA controller, with a full-buffer
// clear sweep after reset or on request.
module pixel_framebuffer
  import pixel_framebuffer_pkg::*;
#(
  parameter int unsigned      DEPTH     = DEPTH_DEF,
  parameter logic [RGB_W-1:0] CLEAR_RGB = CLEAR_RGB_DEF
) (
  input  logic              clock,
  input  logic              reset,
  input  logic [ADDR_W-1:0] pixel_address,
  output logic [RGB_W-1:0]  pixel_rgb,
  input  logic              wr_valid,
  output logic              wr_ready,
  input  logic [RGB_W-1:0]  wr_rgb,
  input  logic              wr_first,
  input  logic              clear_req,
  output logic              busy,
  output logic              frame_done
);

  localparam int unsigned       AW   = idx_width(DEPTH);
  localparam logic [ADDR_W-1:0] LAST = ADDR_W'(DEPTH - 1);

  fb_state_e         r_state, w_state_d;
  logic [ADDR_W-1:0] r_clr_ptr, w_clr_ptr_d;
  logic [ADDR_W-1:0] r_wr_ptr, w_wr_ptr_d;
  logic              r_frame_done, w_frame_done_d;
  logic              r_rd_ok;
  logic              w_we;
  logic [ADDR_W-1:0] w_waddr;
  logic [RGB_W-1:0]  w_wdata;
  logic [RGB_W-1:0]  w_rd_data;

  always_comb begin
    w_state_d      = r_state;
    w_clr_ptr_d    = r_clr_ptr;
    w_wr_ptr_d     = r_wr_ptr;
    w_frame_done_d = 1'b0;
    w_we           = 1'b0;
    w_waddr        = r_wr_ptr;
    w_wdata        = wr_rgb;
    unique case (r_state)
      StClear: begin
        w_we    = 1'b1;
        w_waddr = r_clr_ptr;
        w_wdata = CLEAR_RGB;
        if (clear_req) begin
          w_clr_ptr_d = '0;
        end else if (r_clr_ptr == LAST) begin
          w_state_d   = StLoad;
          w_clr_ptr_d = '0;
          w_wr_ptr_d  = '0;
        end else begin
          w_clr_ptr_d = r_clr_ptr + 16'd1;
        end
      end
      StLoad: begin
        if (wr_valid) begin
          w_we = 1'b1;
          if (wr_first) begin
            w_waddr    = '0;
            w_wr_ptr_d = 16'd1;
          end else if (r_wr_ptr == LAST) begin
            w_wr_ptr_d     = '0;
            w_frame_done_d = 1'b1;
          end else begin
            w_wr_ptr_d = r_wr_ptr + 16'd1;
          end
        end
        if (clear_req) begin
          w_state_d   = StClear;
          w_clr_ptr_d = '0;
        end
      end
      default: w_state_d = StClear;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      r_state      <= StClear;
      r_clr_ptr    <= '0;
      r_wr_ptr     <= '0;
      r_frame_done <= 1'b0;
      r_rd_ok      <= 1'b0;
    end else begin
      r_state      <= w_state_d;
      r_clr_ptr    <= w_clr_ptr_d;
      r_wr_ptr     <= w_wr_ptr_d;
      r_frame_done <= w_frame_done_d;
      r_rd_ok      <= (pixel_address <= LAST);
    end
  end

  // The RAM read register has no reset, so reset and out-of-range reads are masked here.
  fb_ram #(
    .DEPTH (DEPTH),
    .AW    (AW),
    .DW    (RGB_W)
  ) u_ram (
    .i_clk   (clock),
    .i_we    (w_we & ~reset),
    .i_waddr (w_waddr[AW-1:0]),
    .i_wdata (w_wdata),
    .i_raddr (pixel_address[AW-1:0]),
    .o_rdata (w_rd_data)
  );

  assign pixel_rgb  = r_rd_ok ? w_rd_data : '0;
  assign wr_ready   = (r_state == StLoad);
  assign busy       = (r_state == StClear);
  assign frame_done = r_frame_done;

endmodule

// File: tb/tb_pixel_framebuffer.sv
// Directed self-checking bench for pixel_framebuffer at DEPTH=16, CLEAR_RGB=3'b010.
module tb_pixel_framebuffer;

  localparam int unsigned DEPTH = 16;
  localparam logic [2:0]  CLR   = 3'b010;

  logic        clock = 1'b0;
  logic        reset;
  logic [15:0] pixel_address;
  logic [2:0]  pixel_rgb;
  logic        wr_valid;
  logic        wr_ready;
  logic [2:0]  wr_rgb;
  logic        wr_first;
  logic        clear_req;
  logic        busy;
  logic        frame_done;

  int n_chk  = 0;
  int n_pass = 0;

  pixel_framebuffer #(
    .DEPTH     (DEPTH),
    .CLEAR_RGB (CLR)
  ) dut (
    .clock         (clock),
    .reset         (reset),
    .pixel_address (pixel_address),
    .pixel_rgb     (pixel_rgb),
    .wr_valid      (wr_valid),
    .wr_ready      (wr_ready),
    .wr_rgb        (wr_rgb),
    .wr_first      (wr_first),
    .clear_req     (clear_req),
    .busy          (busy),
    .frame_done    (frame_done)
  );

  always #5 clock = ~clock;

  task automatic chk(input string tag, input int got, input int exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic beat(input logic [2:0] rgb, input logic first);
    wr_valid = 1'b1;
    wr_rgb   = rgb;
    wr_first = first;
    tick();
    wr_valid = 1'b0;
    wr_first = 1'b0;
  endtask

  task automatic rd(input logic [15:0] a, output logic [2:0] d);
    pixel_address = a;
    tick();
    d = pixel_rgb;
  endtask

  task automatic wait_sweep(output int n);
    n = 0;
    while (busy && n < 100) begin
      tick();
      n++;
    end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached, expected completion");
    $fatal(1);
  end

  initial begin
    logic [2:0] d;
    logic [2:0] d7;
    int         n;
    int         pulses;

    reset = 1'b1; pixel_address = '0; wr_valid = 1'b0; wr_rgb = '0;
    wr_first = 1'b0; clear_req = 1'b0;
    tick(); tick();
    chk("rst_rgb", pixel_rgb, 0);
    chk("rst_busy", busy, 1);
    chk("rst_ready", wr_ready, 0);
    chk("rst_fdone", frame_done, 0);

    // Sweep after reset
    reset = 1'b0;
    wait_sweep(n);
    chk("sweep_len", n, 16);
    chk("sweep_ready", wr_ready, 1);
    chk("sweep_busy", busy, 0);
    for (int a = 0; a < 16; a++) begin
      rd(16'(a), d);
      chk("clr_rd", d, 3'b010);
    end

    // Frame load and wrap
    pulses = 0;
    for (int i = 0; i < 16; i++) begin
      beat(3'(i), i == 0);
      if (i < 15) pulses += int'(frame_done);
    end
    chk("fd_early", pulses, 0);
    chk("fd_pulse", frame_done, 1);
    tick();
    chk("fd_once", frame_done, 0);
    rd(16'd5, d);  chk("frame_a5", d, 3'b101);
    rd(16'd15, d); chk("frame_a15", d, 3'b111);
    rd(16'd0, d);  chk("frame_a0", d, 3'b000);

    // Out of range
    rd(16'hFFFF, d); chk("oor_ffff", d, 3'b000);
    rd(16'd16, d);   chk("oor_16", d, 3'b000);

    // Stall and realign
    beat(3'b110, 1'b0); beat(3'b001, 1'b0); beat(3'b011, 1'b0);
    repeat (4) tick();
    beat(3'b111, 1'b1);
    rd(16'd0, d); chk("realign_a0", d, 3'b111);
    rd(16'd1, d); chk("realign_a1", d, 3'b001);
    rd(16'd2, d); chk("realign_a2", d, 3'b011);
    beat(3'b110, 1'b0);
    rd(16'd1, d); chk("realign_ptr1", d, 3'b110);
    beat(3'b000, 1'b0); beat(3'b100, 1'b0);
    rd(16'd3, d); chk("pre_coll_a3", d, 3'b100);

    // Same-cycle read/write of address 3
    beat(3'b111, 1'b1); beat(3'b110, 1'b0); beat(3'b000, 1'b0);
    pixel_address = 16'd3;
    beat(3'b011, 1'b0);
    chk("coll_old", pixel_rgb, 3'b100);
    tick();
    chk("coll_new", pixel_rgb, 3'b011);

    // Clear request together with a beat at wr_ptr=7
    beat(3'b100, 1'b0); beat(3'b101, 1'b0); beat(3'b110, 1'b0);
    clear_req = 1'b1;
    beat(3'b001, 1'b0);
    clear_req = 1'b0;
    chk("clrreq_busy", busy, 1);
    chk("clrreq_ready", wr_ready, 0);
    pixel_address = 16'd7;
    n = 0;
    d7 = '0;
    while (busy && n < 100) begin
      tick();
      n++;
      if (n == 1) d7 = pixel_rgb;
    end
    chk("clrreq_len", n, 16);
    chk("clrreq_beat", d7, 3'b001);
    rd(16'd7, d); chk("clrreq_a7", d, 3'b010);

    // Clear request during the sweep restarts it
    clear_req = 1'b1; tick(); clear_req = 1'b0;
    chk("restart_busy", busy, 1);
    repeat (5) tick();
    clear_req = 1'b1; tick(); clear_req = 1'b0;
    wait_sweep(n);
    chk("restart_len", n, 16);

    // Reset mid-sweep at clr_ptr=9
    clear_req = 1'b1; tick(); clear_req = 1'b0;
    repeat (9) tick();
    reset = 1'b1; tick(); reset = 1'b0;
    wait_sweep(n);
    chk("rst_sweep_len", n, 16);

    // Reset mid-frame
    beat(3'b001, 1'b1); beat(3'b011, 1'b0); beat(3'b101, 1'b0);
    pixel_address = 16'd1;
    reset = 1'b1; tick(); reset = 1'b0;
    chk("rst_mask", pixel_rgb, 0);
    chk("rst_frame_ready", wr_ready, 0);
    wait_sweep(n);
    chk("rst_frame_len", n, 16);
    beat(3'b110, 1'b0);
    rd(16'd0, d); chk("rst_frame_ptr0", d, 3'b110);
    rd(16'd1, d); chk("rst_frame_a1", d, 3'b010);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
